// File: rtl/mu0_pkg.sv
// Shared definitions for the memory arbiter: default address/data widths and FSM state encoding.
package mu0_pkg;

    localparam int MAXDEPTH = 12;
    localparam int MAXWIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } arb_state_t;

    // One-hot grant vector: bit 0 = port A, bit 1 = port B.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_A    = 2'b01;
    localparam logic [1:0] GNT_B    = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between ports A and B.
// MEM_ARB_RR_EN defined: round-robin on last_gnt (1 = B granted last); otherwise fixed A priority.
module mem_arb_pick
    import mu0_pkg::*;
(
    input  logic       a_req,
    input  logic       b_req,
`ifdef MEM_ARB_RR_EN
    input  logic       last_gnt,
`endif
    output logic [1:0] grant
);

    always_comb begin
        grant = GNT_NONE;
`ifdef MEM_ARB_RR_EN
        if (a_req && b_req) begin
            grant = last_gnt ? GNT_A : GNT_B;
        end else if (a_req) begin
            grant = GNT_A;
        end else if (b_req) begin
            grant = GNT_B;
        end
`else
        if (a_req) begin
            grant = GNT_A;
        end else if (b_req) begin
            grant = GNT_B;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter: IDLE -> ACCESS -> ACK, one access per three cycles.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: fixed priority to port A).
module mem_arbiter
    import mu0_pkg::*;
#(
    parameter int AW = MAXDEPTH,
    parameter int DW = MAXWIDTH
) (
    input  logic          Clk,
    input  logic          nReset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          mem_wen,
    output logic          mem_ren,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t    r_state;
    arb_state_t    w_next;
    logic [1:0]    r_gnt;
    logic          r_we;
    logic [1:0]    w_grant;
    logic          w_load;
    logic          w_done;
    logic          w_win_we;
    logic [AW-1:0] w_win_addr;
    logic [DW-1:0] w_win_wdata;

`ifdef MEM_ARB_RR_EN
    logic          r_last_b;

    mem_arb_pick u_pick (
        .a_req    (a_req),
        .b_req    (b_req),
        .last_gnt (r_last_b),
        .grant    (w_grant)
    );
`else
    mem_arb_pick u_pick (
        .a_req (a_req),
        .b_req (b_req),
        .grant (w_grant)
    );
`endif

    assign w_win_we    = w_grant[1] ? b_we    : a_we;
    assign w_win_addr  = w_grant[1] ? b_addr  : a_addr;
    assign w_win_wdata = w_grant[1] ? b_wdata : a_wdata;

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    w_next = ST_ACCESS;
                    w_load = 1'b1;
                end
            end
            ST_ACCESS: begin
                w_next = ST_ACK;
                w_done = 1'b1;
            end
            ST_ACK:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // mem_* enables are set on the edge entering ACCESS so they are registered for exactly that cycle.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            r_state   <= ST_IDLE;
            r_gnt     <= GNT_NONE;
            r_we      <= 1'b0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_b  <= 1'b1;
`endif
        end else begin
            r_state <= w_next;
            mem_wen <= w_load & w_win_we;
            mem_ren <= w_load & ~w_win_we;
            a_ack   <= w_done & r_gnt[0];
            b_ack   <= w_done & r_gnt[1];
            if (w_load) begin
                r_gnt     <= w_grant;
                r_we      <= w_win_we;
                mem_addr  <= w_win_addr;
                mem_wdata <= w_win_wdata;
`ifdef MEM_ARB_RR_EN
                r_last_b  <= w_grant[1];
`endif
            end
            if (w_done && !r_we) begin
                if (r_gnt[0]) a_rdata <= mem_rdata;
                if (r_gnt[1]) b_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a falling-edge memory model.
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          Clk = 1'b0;
    logic          nReset;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_wen, mem_ren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_addr];
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Issues one request on a port and waits (bounded) for its ack; returns cycles to ack.
    task automatic run_port(input bit pb, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, output int lat, output bit other_ack);
        if (pb) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        lat = 0;
        other_ack = 1'b0;
        while (lat < 10) begin
            tick();
            lat++;
            if (pb ? a_ack : b_ack) other_ack = 1'b1;
            if (pb ? b_ack : a_ack) break;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        nReset = 1'b0;
        tick();
        tick();
        total++;
        if ({mem_wen, mem_ren, a_ack, b_ack} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000", {mem_wen, mem_ren, a_ack, b_ack});
        end
        total++;
        if (mem_addr !== 12'h000 || mem_wdata !== 16'h0000) begin
            bad++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 000/0000", mem_addr, mem_wdata);
        end
        total++;
        if (a_rdata !== 16'h0000 || b_rdata !== 16'h0000) begin
            bad++; $display("FAIL reset_rdata: got a=%h b=%h want 0000/0000", a_rdata, b_rdata);
        end
        nReset = 1'b1;
        tick();
    endtask

    task automatic test_a_read;
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010; a_wdata = 16'h0000;
        tick();
        total++;
        if ({mem_ren, mem_wen, a_ack} !== 3'b100 || mem_addr !== 12'h010) begin
            bad++; $display("FAIL a_read_access: got ren/wen/ack=%b addr=%h want 100/010",
                            {mem_ren, mem_wen, a_ack}, mem_addr);
        end
        tick();
        total++;
        if (a_ack !== 1'b1 || b_ack !== 1'b0 || a_rdata !== 16'h1234) begin
            bad++; $display("FAIL a_read_ack: got ack=%b/%b rdata=%h want 1/0 1234", a_ack, b_ack, a_rdata);
        end
        a_req = 1'b0;
        tick();
        total++;
        if (a_ack !== 1'b0 || mem_ren !== 1'b0 || a_rdata !== 16'h1234) begin
            bad++; $display("FAIL a_read_after: got ack=%b ren=%b rdata=%h want 0 0 1234", a_ack, mem_ren, a_rdata);
        end
    endtask

    task automatic test_b_write_a_read;
        int lat;
        bit oth;
        run_port(1'b1, 1'b1, 12'h0FF, 16'hBEEF, lat, oth);
        total++;
        if (lat !== 2 || oth !== 1'b0 || b_rdata !== 16'h0000) begin
            bad++; $display("FAIL b_write: got lat=%0d other=%b b_rdata=%h want 2 0 0000", lat, oth, b_rdata);
        end
        run_port(1'b0, 1'b0, 12'h0FF, 16'h0000, lat, oth);
        total++;
        if (lat !== 2 || a_rdata !== 16'hBEEF || b_rdata !== 16'h0000) begin
            bad++; $display("FAIL a_read_bwrite: got lat=%0d a_rdata=%h b_rdata=%h want 2 beef 0000",
                            lat, a_rdata, b_rdata);
        end
    endtask

    task automatic test_wrap;
        int lat;
        bit oth;
        run_port(1'b0, 1'b1, 12'hFFF, 16'h0001, lat, oth);
        total++;
        if (lat !== 2 || mem[12'hFFF] !== 16'h0001) begin
            bad++; $display("FAIL wrap_write: got lat=%0d mem[fff]=%h want 2 0001", lat, mem[12'hFFF]);
        end
        run_port(1'b0, 1'b0, 12'h000, 16'h0000, lat, oth);
        total++;
        if (a_rdata !== 16'h5A5A) begin
            bad++; $display("FAIL wrap_read0: got %h want 5a5a", a_rdata);
        end
        run_port(1'b1, 1'b0, 12'h010, 16'h0000, lat, oth);
        total++;
        if (lat !== 2 || b_rdata !== 16'h1234 || a_rdata !== 16'h5A5A) begin
            bad++; $display("FAIL b_read: got lat=%0d b=%h a=%h want 2 1234 5a5a", lat, b_rdata, a_rdata);
        end
    endtask

    task automatic test_drop;
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h0FF;
        tick();
        a_req = 1'b0;
        tick();
        total++;
        if (a_ack !== 1'b1 || a_rdata !== 16'hBEEF) begin
            bad++; $display("FAIL drop_req: got ack=%b rdata=%h want 1 beef", a_ack, a_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int acks[$];
        a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (a_ack) acks.push_back(c);
            if (acks.size() == 2) break;
        end
        a_req = 1'b0;
        tick();
        tick();
        total++;
        if (acks.size() != 2) begin
            bad++; $display("FAIL b2b_count: got %0d acks want 2", acks.size());
        end else begin
            total++;
            if (acks[0] != 2 || acks[1] != 5) begin
                bad++; $display("FAIL b2b_timing: got cycles %0d,%0d want 2,5", acks[0], acks[1]);
            end
        end
    endtask

    task automatic test_simultaneous;
        logic [3:0] exp_win;
        logic [3:0] win;
        int         cyc [4];
        int         n;
        bit         both;
`ifdef MEM_ARB_RR_EN
        exp_win = 4'b1010;
`else
        exp_win = 4'b0000;
`endif
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 12'h020; a_wdata = 16'h1111;
        b_req = 1'b1; b_we = 1'b1; b_addr = 12'h021; b_wdata = 16'h2222;
        n = 0;
        both = 1'b0;
        win = 4'b0000;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (a_ack && b_ack) both = 1'b1;
            if (a_ack || b_ack) begin
                win[n] = b_ack;
                cyc[n] = c;
                n++;
                if (n == 4) break;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        tick();
        total++;
        if (n != 4 || both) begin
            bad++; $display("FAIL simul_count: got %0d acks both=%b want 4 0", n, both);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (win[i] !== exp_win[i] || cyc[i] != 2 + 3 * i) begin
                    bad++; $display("FAIL simul_grant%0d: got port=%b cycle=%0d want port=%b cycle=%0d",
                                    i, win[i], cyc[i], exp_win[i], 2 + 3 * i);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        a_req = 1'b1; a_we = 1'b1; a_addr = 12'h030; a_wdata = 16'h7777;
        tick();
        total++;
        if (mem_wen !== 1'b1 || mem_addr !== 12'h030) begin
            bad++; $display("FAIL mid_access: got wen=%b addr=%h want 1 030", mem_wen, mem_addr);
        end
        nReset = 1'b0;
        a_req = 1'b0;
        tick();
        total++;
        if ({mem_wen, mem_ren, a_ack, b_ack} !== 4'b0000 || mem_addr !== 12'h000 || mem_wdata !== 16'h0000
            || a_rdata !== 16'h0000 || b_rdata !== 16'h0000) begin
            bad++; $display("FAIL mid_reset: got ctl=%b addr=%h wd=%h a=%h b=%h want all zero",
                            {mem_wen, mem_ren, a_ack, b_ack}, mem_addr, mem_wdata, a_rdata, b_rdata);
        end
        nReset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (a_ack || b_ack || mem_wen || mem_ren) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL mid_idle: got activity=%b want 0", seen);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[12'h010] = 16'h1234;
        mem[12'h000] = 16'h5A5A;
        nReset = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        test_reset();
        test_a_read();
        test_b_write_a_read();
        test_wrap();
        test_drop();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
